// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush.
module fifo_sync_param #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AF_LVL = 14,
    parameter int unsigned AE_LVL = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic             WR,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             RD,
    output logic [WIDTH-1:0] dataOut,
    output logic             EMPTY,
    output logic             FULL,
    output logic             AEMPTY,
    output logic             AFULL,
    output logic [CW-1:0]    COUNT,
    output logic             OVF,
    output logic             UDF
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LVL);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             empty, full;
    logic             wr_acc, rd_acc;

    // Status is decoded only from registered count, never from the request inputs.
    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_C);

    assign wr_acc = EN & WR & ~full & ~FLUSH;
    assign rd_acc = EN & RD & ~empty & ~FLUSH;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (EN && FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
                dout_d   = mem[rd_ptr_q];
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (EN && WR && full) ovf_d = 1'b1;
            if (EN && RD && empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage has no reset; only the pointers define valid contents.
    always_ff @(posedge Clk) begin
        if (!Rst && wr_acc) begin
            mem[wr_ptr_q] <= dataIn;
        end
    end

    assign dataOut = dout_q;
    assign COUNT   = count_q;
    assign EMPTY   = empty;
    assign FULL    = full;
    assign AEMPTY  = (count_q <= AE_C);
    assign AFULL   = (count_q >= AF_C);
    assign OVF     = ovf_q;
    assign UDF     = udf_q;

endmodule
